// File: rtl/obi_burst_master.sv
// Expands one read/write burst command into single-word OBI requests.
// Read responses are buffered; a read is only issued when its response has a reserved FIFO slot.
module obi_burst_master #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RFIFO_DEPTH     = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic                    wdata_valid_i,
  output logic                    wdata_ready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wbe_i,
  output logic                    rdata_valid_o,
  input  logic                    rdata_ready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rerr_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
  input  logic                    obi_err_i,
  output logic                    done_o,
  output logic                    err_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CNT_W    = $clog2(RFIFO_DEPTH + 1);
  localparam int unsigned PTR_W    = (RFIFO_DEPTH > 1) ? $clog2(RFIFO_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(BE_WIDTH);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(RFIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [OUT_W-1:0]      outst_q;
  logic [CNT_W-1:0]      fcnt_q;
  logic [PTR_W-1:0]      wptr_q;
  logic [PTR_W-1:0]      rptr_q;
  logic                  err_q;
  logic                  done_q;
  logic                  done_err_q;
  logic [DATA_WIDTH:0]   fifo_mem [RFIFO_DEPTH];

  logic cmd_hs;
  logic gnt_hs;
  logic last_gnt;
  logic rsp;
  logic push;
  logic pop;
  logic read_room;
  logic can_issue;
  logic drain_done;

  assign cmd_ready_o = ~rst_i & (state_q == IDLE) & ~done_q;
  assign cmd_hs      = cmd_valid_i & cmd_ready_o;

  // Reserve a FIFO slot per in-flight read, since responses cannot be stalled.
  assign read_room = (32'(outst_q) + 32'(fcnt_q)) < RFIFO_DEPTH;
  assign can_issue = (state_q == ISSUE) & (issued_q < len_q) &
                     (32'(outst_q) < MAX_OUTSTANDING) &
                     (we_q ? wdata_valid_i : read_room);

  assign obi_req_o     = ~rst_i & can_issue;
  assign obi_addr_o    = addr_q;
  assign obi_we_o      = we_q;
  assign obi_be_o      = we_q ? wbe_i : '1;
  assign obi_wdata_o   = we_q ? wdata_i : '0;
  assign gnt_hs        = obi_req_o & obi_gnt_i;
  assign wdata_ready_o = gnt_hs & we_q;
  assign last_gnt      = gnt_hs & ((issued_q + LEN_WIDTH'(1)) == len_q);

  assign rsp  = obi_rvalid_i & (outst_q != '0);
  assign push = rsp & ~we_q;
  assign pop  = rdata_valid_o & rdata_ready_i;

  assign rdata_valid_o     = ~rst_i & (fcnt_q != '0);
  assign {rerr_o, rdata_o} = fifo_mem[rptr_q];

  assign drain_done = (state_q == DRAIN) & (outst_q == '0);
  assign done_o     = ~rst_i & done_q;
  assign err_o      = ~rst_i & done_err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_hs) state_d = (cmd_len_i != '0) ? ISSUE : DRAIN;
      ISSUE:   if (last_gnt) state_d = DRAIN;
      DRAIN:   if (outst_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      outst_q    <= '0;
      fcnt_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= drain_done;
      done_err_q <= drain_done & err_q;

      if (cmd_hs) begin
        we_q     <= cmd_we_i;
        addr_q   <= cmd_addr_i;
        len_q    <= cmd_len_i;
        issued_q <= '0;
        err_q    <= 1'b0;
      end else begin
        if (gnt_hs) begin
          issued_q <= issued_q + LEN_WIDTH'(1);
          addr_q   <= addr_q + STRIDE;
        end
        if (rsp & obi_err_i) err_q <= 1'b1;
      end

      unique case ({gnt_hs, rsp})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase

      if (push) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + CNT_W'(1);
        2'b01:   fcnt_q <= fcnt_q - CNT_W'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= {obi_err_i, obi_rdata_i};
  end

endmodule

// File: tb/tb_obi_burst_master.sv
// Randomized bench for obi_burst_master: an OBI slave, write source and read sink
// drive the DUT while a transaction-level model of the burst predicts every observable output.
module tb_obi_burst_master;

  localparam int AW = 32, DW = 32, LW = 8, MAXO = 4, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cmd_valid, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid;
  logic [DW-1:0] wdata;
  logic [3:0]    wbe;
  logic          rdata_ready;
  logic          obi_gnt, obi_rvalid, obi_err;
  logic [DW-1:0] obi_rdata;
  logic          cmd_ready_o, wdata_ready_o, rdata_valid_o, rerr_o;
  logic [DW-1:0] rdata_o, obi_wdata_o;
  logic          obi_req_o, obi_we_o, done_o, err_o;
  logic [AW-1:0] obi_addr_o;
  logic [3:0]    obi_be_o;

  obi_burst_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .MAX_OUTSTANDING(MAXO), .RFIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata), .wbe_i(wbe),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready), .rdata_o(rdata_o), .rerr_o(rerr_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .obi_err_i(obi_err),
    .done_o(done_o), .err_o(err_o)
  );

  int chk = 0, fails = 0, cyc = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Environment knobs
  int gnt_pct = 100, gnt_delay = -1, lat_min = 1, lat_max = 1, rdy_pct = 100, wv_pct = 100;
  logic [31:0] rd_base = 32'h0, err_mask = 32'h0;

  // Command driver
  bit cmd_pending = 0, rst_drv = 0, c_we = 0;
  logic [31:0] c_addr = '0;
  int c_len = 0;

  // Burst model
  bit burst_active = 0, cur_we = 0, err_acc = 0, src_hold = 0, last_err = 0;
  logic [31:0] cur_addr = '0;
  int cur_len = 0, iss = 0, src_idx = 0, out_m = 0, hs_cyc = 0, done_cyc = 0;
  int n_grants = 0, n_wr = 0, stall_cnt = 0;
  logic [31:0] wr_words [256];
  logic [3:0]  wr_be    [256];

  typedef struct {
    bit          we;
    int          due;
    bit          stale;
    logic [31:0] data;
    bit          err;
  } pend_t;
  pend_t       pend[$];
  logic [32:0] exp_rq[$];
  logic [31:0] gaddr[$];
  int          gcyc[$];
  logic [32:0] rd_log[$];

  bit prev_stall = 0, p_we = 0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0]  p_be = '0;

  task automatic step();
    pend_t       rsp_e;
    bit          rsp_now;
    bit          gw;
    bit          legal;
    logic [31:0] ea;
    logic [32:0] e;
    rsp_now = 0;
    @(negedge clk);
    rst = rst_drv;
    if (rst_drv) begin
      foreach (pend[i]) pend[i].stale = 1;
      exp_rq.delete();
      out_m = 0; burst_active = 0; cmd_pending = 0; src_hold = 0; prev_stall = 0; stall_cnt = 0;
    end
    obi_rvalid = 0; obi_rdata = $urandom; obi_err = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_e = pend.pop_front();
      rsp_now = 1;
      obi_rvalid = 1;
      obi_rdata = rsp_e.we ? $urandom : rsp_e.data;
      obi_err = rsp_e.err;
    end
    obi_gnt = (gnt_delay >= 0) ? (stall_cnt >= gnt_delay) : ($urandom_range(99) < gnt_pct);
    rdata_ready = ($urandom_range(99) < rdy_pct);
    cmd_valid = cmd_pending; cmd_we = c_we; cmd_addr = c_addr; cmd_len = LW'(c_len);
    if (!src_hold) begin
      wdata_valid = 0; wdata = $urandom; wbe = 4'($urandom);
      if (!rst_drv && burst_active && cur_we && src_idx < cur_len && $urandom_range(99) < wv_pct) begin
        wdata_valid = 1; wdata = wr_words[src_idx]; wbe = wr_be[src_idx]; src_hold = 1;
      end
    end
    #1;
    if (rst_drv) begin
      check_eq("reset_outputs",
               {obi_req_o, rdata_valid_o, done_o, err_o, wdata_ready_o, cmd_ready_o}, 6'b0);
    end else begin
      check_eq("cmd_ready", cmd_ready_o, !burst_active);
      if (prev_stall) begin
        check_eq("req_hold", obi_req_o, 1'b1);
        check_eq("addr_hold", obi_addr_o, p_addr);
        check_eq("we_hold", obi_we_o, p_we);
        if (p_we) check_eq("wdata_hold", {obi_be_o, obi_wdata_o}, {p_be, p_wdata});
      end
      if (done_o) begin
        check_eq("done_expected", burst_active && iss == cur_len && out_m == 0, 1'b1);
        check_eq("err_o", err_o, err_acc);
        last_err = err_o; done_cyc = cyc; burst_active = 0;
      end
      if (obi_req_o) begin
        legal = burst_active && iss < cur_len && out_m < MAXO &&
                (cur_we ? wdata_valid : (out_m + exp_rq.size() < DEPTH));
        check_eq("req_legal", legal, 1'b1);
      end
      gw = obi_req_o && obi_gnt;
      check_eq("wdata_ready", wdata_ready_o, gw && cur_we);
      if (wdata_ready_o) n_wr++;
      if (gw) begin
        ea = cur_addr + 32'(iss * 4);
        check_eq("obi_addr", obi_addr_o, ea);
        check_eq("obi_we", obi_we_o, cur_we);
        if (cur_we) begin
          check_eq("obi_wdata", {obi_be_o, obi_wdata_o}, {wr_be[iss], wr_words[iss]});
          src_hold = 0; src_idx++;
        end
        gaddr.push_back(obi_addr_o); gcyc.push_back(cyc);
        pend.push_back('{we: cur_we, due: cyc + $urandom_range(lat_min, lat_max), stale: 0,
                         data: rd_base + 32'(iss), err: (iss < 32) ? err_mask[iss] : 1'b0});
        iss++; n_grants++; out_m++;
      end
      prev_stall = obi_req_o && !obi_gnt;
      stall_cnt = prev_stall ? stall_cnt + 1 : 0;
      p_addr = obi_addr_o; p_we = obi_we_o; p_be = obi_be_o; p_wdata = obi_wdata_o;
      check_eq("rdata_valid", rdata_valid_o, exp_rq.size() != 0);
      if (rdata_valid_o && rdata_ready && exp_rq.size() > 0) begin
        e = exp_rq.pop_front();
        check_eq("rdata", {rerr_o, rdata_o}, e);
        rd_log.push_back({rerr_o, rdata_o});
      end
      if (rsp_now && !rsp_e.stale) begin
        out_m--;
        err_acc |= rsp_e.err;
        if (!rsp_e.we) exp_rq.push_back({rsp_e.err, rsp_e.data});
      end
      if (cmd_valid && cmd_ready_o) begin
        cmd_pending = 0; burst_active = 1; cur_we = c_we; cur_addr = c_addr; cur_len = c_len;
        iss = 0; src_idx = 0; src_hold = 0; err_acc = 0; hs_cyc = cyc;
        n_grants = 0; n_wr = 0; gaddr.delete(); gcyc.delete();
      end
    end
    cyc++;
  endtask

  task automatic start_cmd(input bit we, input logic [31:0] addr, input int len);
    c_we = we; c_addr = addr; c_len = len;
    for (int i = 0; i < len; i++) begin
      wr_words[i] = $urandom;
      wr_be[i] = 4'($urandom);
    end
    cmd_pending = 1;
    for (int n = 0; n < 300 && cmd_pending; n++) step();
    check_eq("cmd_accept", cmd_pending, 1'b0);
  endtask

  task automatic wait_done(input int limit);
    for (int n = 0; n < limit && burst_active; n++) step();
    check_eq("done_in_time", burst_active, 1'b0);
  endtask

  task automatic drain();
    int saved;
    saved = rdy_pct; rdy_pct = 100;
    for (int n = 0; n < 200 && exp_rq.size() > 0; n++) step();
    repeat (2) step();
    rdy_pct = saved;
  endtask

  logic [31:0] t1_addr [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};

  initial begin
    rst = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 0; wdata = '0; wbe = '0; rdata_ready = 0;
    obi_gnt = 0; obi_rvalid = 0; obi_rdata = '0; obi_err = 0;
    rst_drv = 1;
    repeat (3) step();
    rst_drv = 0;
    step();

    // Read burst, zero-wait grants, responses one cycle later
    rd_base = 32'hA0; err_mask = 0; rd_log.delete();
    start_cmd(0, 32'h1000, 4);
    wait_done(200);
    drain();
    check_eq("t1_grants", gaddr.size(), 4);
    for (int i = 0; i < 4 && i < gaddr.size(); i++) begin
      check_eq("t1_addr", gaddr[i], t1_addr[i]);
      check_eq("t1_back_to_back", gcyc[i] - gcyc[0], i);
    end
    check_eq("t1_nread", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++)
      check_eq("t1_rdata", rd_log[i], {1'b0, 32'hA0 + 32'(i)});
    check_eq("t1_err", last_err, 1'b0);

    // Write burst, toggling source, grant after two stall cycles
    gnt_delay = 2; wv_pct = 50;
    start_cmd(1, 32'h2000, 3);
    wait_done(300);
    check_eq("t2_wready_pulses", n_wr, 3);
    check_eq("t2_addr_last", gaddr[gaddr.size()-1], 32'h2008);
    for (int i = 1; i < gcyc.size(); i++)
      check_eq("t2_gnt_spacing", gcyc[i] - gcyc[i-1] >= 3, 1'b1);
    gnt_delay = -1; wv_pct = 100;
    step();

    // Read with a stalled sink: issue stops at the buffer limit
    rd_base = 32'h300; rdy_pct = 0;
    start_cmd(0, 32'h3000, 8);
    repeat (20) step();
    check_eq("t3_grants_stalled", n_grants, 4);
    check_eq("t3_buffered", exp_rq.size(), 4);
    rdy_pct = 100;
    wait_done(300);
    check_eq("t3_grants_total", n_grants, 8);
    drain();

    // Error on second response, then a clean burst
    rd_base = 32'h55; err_mask = 32'h2; rd_log.delete();
    start_cmd(0, 32'h4000, 2);
    wait_done(200);
    drain();
    check_eq("t4_err", last_err, 1'b1);
    check_eq("t4_nread", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check_eq("t4_rerr0", rd_log[0][32], 1'b0);
      check_eq("t4_rerr1", rd_log[1][32], 1'b1);
    end
    err_mask = 0;
    start_cmd(0, 32'h4100, 1);
    wait_done(200);
    drain();
    check_eq("t4_err_cleared", last_err, 1'b0);

    // Zero-length command, then an address wrap
    start_cmd(1, 32'h5000, 0);
    wait_done(50);
    check_eq("t5_no_req", n_grants, 0);
    check_eq("t5_done_delay", done_cyc - hs_cyc, 2);
    start_cmd(0, 32'hFFFF_FFFC, 2);
    wait_done(200);
    drain();
    check_eq("t5_wrap0", gaddr.size() > 0 ? gaddr[0] : 32'h1, 32'hFFFF_FFFC);
    check_eq("t5_wrap1", gaddr.size() > 1 ? gaddr[1] : 32'h1, 32'h0);

    // Reset mid-burst with late responses
    lat_min = 4; lat_max = 4; rd_base = 32'h600;
    start_cmd(0, 32'h6000, 4);
    for (int n = 0; n < 100 && n_grants < 2; n++) step();
    check_eq("t6_two_granted", n_grants, 2);
    rst_drv = 1;
    repeat (2) step();
    rst_drv = 0;
    for (int n = 0; n < 50 && pend.size() > 0; n++) step();
    repeat (2) step();
    lat_min = 1; lat_max = 2; rd_base = 32'h700; rd_log.delete();
    start_cmd(0, 32'h7000, 3);
    wait_done(200);
    drain();
    check_eq("t6_post_grants", n_grants, 3);
    check_eq("t6_post_reads", rd_log.size(), 3);
    if (rd_log.size() == 3) check_eq("t6_post_last", rd_log[2], {1'b0, 32'h702});

    // Randomized bursts
    for (int b = 0; b < 30; b++) begin
      gnt_pct = $urandom_range(30, 100);
      lat_min = $urandom_range(1, 2);
      lat_max = lat_min + $urandom_range(0, 3);
      rdy_pct = $urandom_range(20, 100);
      wv_pct = $urandom_range(30, 100);
      rd_base = $urandom;
      err_mask = $urandom & $urandom & $urandom;
      start_cmd(1'($urandom), ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom,
                $urandom_range(0, 12));
      wait_done(3000);
      if ($urandom_range(1) == 1) drain();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
